sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, byte-wide first-in/first-out buffer for the debug-core datapath. It decouples a producer, such as the UART receive path, from a consumer, such as the command decoder. It stores up to DEPTH−1 entries in an inferred block RAM and reports occupancy, empty and full status every cycle.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 4096: RAM entries; must be a power of two. Usable capacity is DEPTH−1.
- `AW`, derived as $clog2(DEPTH) (12 by default): width of the pointers and of `size`.

Ports:
- `clk`  input  1  sole clock; all logic is rising-edge.
- `rst`  input  1  reset; synchronous, active-high.
- `data_in`  input  WIDTH  write data.
- `input_ready`  input  1  write strobe; one word per cycle while high.
- `request_output`  input  1  read strobe; one word per cycle while high.
- `data_out`  output  WIDTH  read data (registered).
- `size`  output  AW  current occupancy, 0..DEPTH−1.
- `empty`  output  1  high when `size` == 0.
- `full`  output  1  high when `size` == DEPTH−1.

## Operation
- State consists of the AW-bit pointers `wr_ptr` and `rd_ptr`. Both wrap modulo DEPTH.
- `size` = `wr_ptr` − `rd_ptr`, computed modulo 2^AW. `empty` and `full` are decoded from `size`.
- Write accept = `input_ready` && !`full`. On accept, store `data_in` at `wr_ptr` and increment `wr_ptr`. A write while full is silently dropped.
- Read accept = `request_output` && !`empty`. On accept, load mem[`rd_ptr`] into `data_out` and increment `rd_ptr`. A read while empty is ignored.
- `data_out` holds its last value whenever no read is accepted.
- Accept decisions use the state at the start of the cycle.
  - Simultaneous write and read while full: the read proceeds and the write is dropped.
  - Simultaneous write and read while empty: the write proceeds and the read is ignored.
  - Simultaneous write and read otherwise: both proceed and `size` is unchanged.
- No state machine; the block is pointer arithmetic only.

## Timing
- Reset (synchronous): on the edge where `rst`=1, `wr_ptr` and `rd_ptr` go to 0, so `size`=0, `empty`=1, `full`=0. `data_out` goes to 0.
- Reset mid-operation discards all contents, and any strobe on the reset edge is ignored. RAM contents are not cleared.
- A write accepted at edge t is reflected in `size`, `empty` and `full` immediately after edge t.
- The written word is readable by a read accepted at edge t+1 or later.
- Read latency is 1 cycle: a read accepted at edge t presents its word on `data_out` after edge t.
- Sustained throughput is one write and one read per cycle.

## Configuration
- `SYNC_FIFO_OUTREG_EN` defined: adds a second pipeline register after the RAM read.
  - Read latency becomes 2 cycles and `data_out` lags the read accept by two edges.
  - Flag and `size` timing are unchanged.
  - The extra register resets to 0.
- `SYNC_FIFO_OUTREG_EN` undefined: single-register read with 1-cycle latency, as specified above.

## Structure
- Package `sync_fifo_pkg` holds:
  - `WIDTH`/`DEPTH` default constants;
  - the `data_t` typedef (logic [WIDTH-1:0]);
  - the `ptr_t` typedef (logic [AW-1:0]).
- Sub-module `sync_fifo_ram` is a simple dual-port RAM.
  - One write port and one registered read port, both on `clk`.
  - No reset.
  - Must infer block RAM.
- The top level holds the pointers, accept logic, flag decode and the optional output register.

## Test plan
- Reset → `size`=0, `empty`=1, `full`=0, `data_out`=0x00; strobes asserted during reset have no effect.
- Write single 0xA5 then read → `size` goes 0→1→0; `data_out`=0xA5 one cycle after the read strobe (two cycles with the macro).
- Write 4097 words with `data_in`=i[7:0] for i=0..4096 → `full` rises after the 4095th write with `size`=4095; the last two writes are dropped.
- Then read for 4097 cycles → `data_out` sequence is 0x00,0x01,…,0xFF repeating up to 0xFE at entry 4094. It then holds 0xFE, `empty`=1 and `size`=0.
- Fill to `size`=3 and hold both strobes for 10 cycles → `size` stays 3; output order matches input order.
- Fill to full, strobe both → read accepted, write dropped, `size`=4094. Read on empty → `data_out` unchanged and `size` stays 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the sync_fifo block.
// The default build uses an 8-bit word and a 4096-entry RAM.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4096;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_AW-1:0]    ptr_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port and one registered read port, both on clk.
// The read register holds its value while the read enable is low.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    // NOTE: neither the array nor the read register has a reset, so the tools can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with DEPTH-1 usable entries, occupancy and empty/full flags.
// Define SYNC_FIFO_OUTREG_EN to add a second output register (2-cycle read latency).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             input_ready,
    input  logic             request_output,
    output logic [WIDTH-1:0] data_out,
    output logic [AW-1:0]    size,
    output logic             empty,
    output logic             full
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] SIZE_MAX = AW'(DEPTH - 1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_rd_seen;
    logic [AW-1:0]    w_size;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_ram_rdata;
    logic [WIDTH-1:0] w_stage1;

    // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
    always_comb begin
        w_size   = r_wr_ptr - r_rd_ptr;
        w_empty  = (w_size == '0);
        w_full   = (w_size == SIZE_MAX);
        w_wr_acc = input_ready    && !w_full  && !rst;
        w_rd_acc = request_output && !w_empty && !rst;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_seen <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_rd_seen <= 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rdata)
    );

    // The RAM read register cannot be reset, so the output reads as zero until the first read after reset.
    assign w_stage1 = r_rd_seen ? w_ram_rdata : '0;

`ifdef SYNC_FIFO_OUTREG_EN
    logic [WIDTH-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_stage1;
        end
    end

    assign data_out = r_data_out;
`else
    assign data_out = w_stage1;
`endif

    assign size  = w_size;
    assign empty = w_empty;
    assign full  = w_full;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: the driver models the FIFO and queues expected output words,
// and a negedge monitor compares data_out, size and flags every cycle.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4096;
`ifdef SYNC_FIFO_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int    due;
        data_t data;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  input_ready;
    logic  request_output;
    data_t data_in;
    data_t data_out;
    ptr_t  size;
    logic  empty;
    logic  full;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .input_ready    (input_ready),
        .request_output (request_output),
        .data_out       (data_out),
        .size           (size),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    data_t model_q[$];
    exp_t  exp_q[$];
    int    edge_n   = 0;
    bit    mon_en   = 1'b0;
    data_t cur_exp  = '0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, req);
        end
    endtask

    // One clock of stimulus; the model is advanced using the occupancy from before the edge.
    task automatic step(input bit r, input bit wr, input data_t d, input bit rd);
        bit    wa;
        bit    ra;
        data_t v;
        @(negedge clk);
        rst            = r;
        input_ready    = wr;
        data_in        = d;
        request_output = rd;
        @(posedge clk);
        edge_n++;
        if (r) begin
            model_q.delete();
            exp_q.delete();
            exp_q.push_back('{due: edge_n, data: '0});
            mon_en = 1'b1;
        end else begin
            wa = wr && (model_q.size() != DEPTH - 1);
            ra = rd && (model_q.size() != 0);
            if (ra) begin
                v = model_q.pop_front();
                exp_q.push_back('{due: edge_n + LAT - 1, data: v});
            end
            if (wa) begin
                model_q.push_back(d);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (exp_q.size() != 0 && exp_q[0].due <= edge_n) begin
                e       = exp_q.pop_front();
                cur_exp = e.data;
            end
            check("size", 32'(size), 32'(model_q.size()));
            check("empty", 32'(empty), 32'(model_q.size() == 0));
            check("full", 32'(full), 32'(model_q.size() == DEPTH - 1));
            check("data_out", 32'(data_out), 32'(cur_exp));
        end
    end

    initial begin
        rst            = 1'b0;
        input_ready    = 1'b0;
        request_output = 1'b0;
        data_in        = '0;

        // Reset with both strobes asserted: nothing may be stored or read.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Single word round trip.
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Overfill: the last two writes are dropped.
        for (int i = 0; i <= 4096; i++) begin
            step(1'b0, 1'b1, data_t'(i), 1'b0);
        end
        // Drain, then keep reading on empty.
        for (int i = 0; i < 4097; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Steady state at size 3 with both strobes held.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, data_t'(16 + k), 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, data_t'(32 + k), 1'b1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-operation with one word still stored and strobes asserted.
        step(1'b1, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill to full, then simultaneous strobes: read wins, write dropped.
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 1'b1, data_t'(i * 3), 1'b0);
        end
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < DEPTH - 2; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        // Reads on empty must leave data_out and size alone.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
        end
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
